// File: rtl/mul_div_unit.sv
// Iterative 64-bit multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN to give MULH, DIV and REM two's-complement semantics.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [63:0] opA,
    input  logic [63:0] opB,
    input  logic [5:0]  rdAddr,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic [5:0]  resultAddr,
    output logic        writeEn
);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_MULX  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;
    localparam logic [6:0] LAST_CNT = 7'd64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [6:0]   r_cnt;
    logic         r_busy;
    logic         r_done;
    logic         r_we;
    logic [63:0]  r_result;
    logic [5:0]   r_result_addr;

    logic [2:0]   r_op;
    logic [5:0]   r_addr;
    logic         r_a_neg;
    logic         r_b_neg;
    logic         r_b_zero;
    logic [63:0]  r_opa;
    logic [63:0]  r_mcand;
    logic [127:0] r_prod;
    logic [63:0]  r_divisor;
    logic [63:0]  r_quo;
    logic [63:0]  r_rem;

    logic         w_signed_op;
    logic         w_a_neg;
    logic         w_b_neg;
    logic [63:0]  w_a_mag;
    logic [63:0]  w_b_mag;
    logic         w_accept;
    logic         w_iterate;
    logic [64:0]  w_mul_sum;
    logic [64:0]  w_rem_shift;
    logic         w_sub_ok;
    logic [63:0]  w_rem_diff;
    logic [127:0] w_prod_fix;
    logic [63:0]  w_quo_fix;
    logic [63:0]  w_rem_fix;
    logic [63:0]  w_final;

`ifdef MULDIV_SIGNED_EN
    assign w_signed_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`else
    assign w_signed_op = 1'b0;
`endif

    // Signed operands run through the unsigned datapath as magnitudes.
    assign w_a_neg = w_signed_op & opA[63];
    assign w_b_neg = w_signed_op & opB[63];
    assign w_a_mag = w_a_neg ? (~opA + 64'd1) : opA;
    assign w_b_mag = w_b_neg ? (~opB + 64'd1) : opB;

    assign w_accept  = rst_n && (r_state == S_IDLE) && start;
    assign w_iterate = (r_state == S_RUN) && (r_cnt != LAST_CNT);

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the 129-bit value right.
    assign w_mul_sum = {1'b0, r_prod[127:64]} + (r_prod[0] ? {1'b0, r_mcand} : 65'd0);

    // Restoring step: the remainder is always below the divisor, so the
    // difference fits in 64 bits whenever the subtraction is taken.
    assign w_rem_shift = {r_rem, r_quo[63]};
    assign w_sub_ok    = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_diff  = w_rem_shift[63:0] - r_divisor;

    assign w_prod_fix = (r_a_neg ^ r_b_neg) ? (~r_prod + 128'd1) : r_prod;
    assign w_quo_fix  = r_b_zero ? {64{1'b1}}
                      : ((r_a_neg ^ r_b_neg) ? (~r_quo + 64'd1) : r_quo);
    assign w_rem_fix  = r_b_zero ? r_opa
                      : (r_a_neg ? (~r_rem + 64'd1) : r_rem);

    always_comb begin
        w_final = w_prod_fix[63:0];
        case (r_op)
            OP_MUL, OP_MULX:  w_final = w_prod_fix[63:0];
            OP_MULH, OP_MULHU: w_final = w_prod_fix[127:64];
            OP_DIV, OP_DIVU:  w_final = w_quo_fix;
            OP_REM, OP_REMU:  w_final = w_rem_fix;
            default:          w_final = w_prod_fix[63:0];
        endcase
    end

    // NOTE: the datapath registers carry no reset; every one of them is
    // loaded at the accepting edge before it is ever read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= op;
            r_addr    <= rdAddr;
            r_a_neg   <= w_a_neg;
            r_b_neg   <= w_b_neg;
            r_b_zero  <= (opB == 64'd0);
            r_opa     <= opA;
            r_mcand   <= w_a_mag;
            r_prod    <= {64'd0, w_b_mag};
            r_divisor <= w_b_mag;
            r_quo     <= w_a_mag;
            r_rem     <= 64'd0;
        end else if (w_iterate) begin
            r_prod <= {w_mul_sum, r_prod[63:1]};
            r_quo  <= {r_quo[62:0], w_sub_ok};
            r_rem  <= w_sub_ok ? w_rem_diff : w_rem_shift[63:0];
        end
    end

    // Control FSM; the 65th RUN edge applies sign correction and registers the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 7'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_we          <= 1'b0;
            r_result      <= 64'd0;
            r_result_addr <= 6'd0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= 7'd0;
                    end
                end
                S_RUN: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state       <= S_DONE;
                        r_done        <= 1'b1;
                        r_we          <= (r_addr != 6'd0);
                        r_result      <= w_final;
                        r_result_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign writeEn    = r_we;
    assign result     = r_result;
    assign resultAddr = r_result_addr;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed here, clock and reset first.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  3  000 MUL, 001 MULH, 010 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 011 is treated as MUL.
REQ-006 opA  input  64  first operand (register-file read1).
REQ-007 opB  input  64  second operand (register-file read2).
REQ-008 rdAddr  input  6  destination register address.
REQ-009 busy  output  1  high from acceptance through the DONE cycle.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  64  computed value; feeds register-file writeData.
REQ-012 resultAddr  output  6  latched rdAddr; feeds register-file addressw.
REQ-013 writeEn  output  1  one-cycle write strobe; feeds register-file writeEn.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE, with these transitions:
- IDLE->RUN when start=1 at a rising edge (the accepting edge E0); opA, opB, op and rdAddr are latched at E0.
- RUN->DONE after exactly 64 iteration cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-015 Inputs SHALL be ignored outside the accepting edge: start while busy=1 is dropped, and operand changes after E0 have no effect.
REQ-016 The multiply SHALL be an iterative shift-add, one bit per RUN cycle, into a 128-bit product.
- MUL returns product[63:0].
- MULH and MULHU return product[127:64].
REQ-017 The divide SHALL be iterative restoring, one quotient bit per RUN cycle.
- DIV and DIVU return the quotient.
- REM and REMU return the remainder.
REQ-018 Divide by zero: quotient = 64'hFFFF_FFFF_FFFF_FFFF and remainder = opA, with no exception.
REQ-019 Signed overflow (opA = 64'h8000_0000_0000_0000, opB = -1, DIV/REM): quotient = opA, remainder = 0.
REQ-020 Latency and timing:
- busy rises after E0.
- done, writeEn and the final result/resultAddr are valid in the cycle following edge E0+65.
- busy falls at the same edge that drops done.
- An input start in that IDLE cycle is accepted normally.
REQ-021 writeEn SHALL pulse with done only when resultAddr != 0; for rdAddr = 0, done still pulses and writeEn stays 0.
REQ-022 result and resultAddr SHALL hold their last values until the next DONE; they may show intermediate values during RUN, and consumers use them only while done=1.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE in any state, including mid-RUN, and discard the operation in progress.
REQ-024 Reset values SHALL be: busy=0, done=0, writeEn=0, result=0, resultAddr=0, and the iteration counter 0.
REQ-025 A start sampled at the edge where rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro MULDIV_SIGNED_EN, when defined, SHALL give MULH, DIV and REM two's-complement semantics:
- Operands are converted to magnitudes and the result sign is corrected after the iteration.
- Latency is unchanged.
REQ-027 Without MULDIV_SIGNED_EN, MULH, DIV and REM SHALL behave exactly as MULHU, DIVU and REMU, and REQ-019 does not apply.

Verification
REQ-028 MUL: opA = 64'h1234567890ABCDEF, opB = 2, rdAddr = 1 -> done=1 and writeEn=1 at E0+65, result = 64'h2468ACF121579BDE, resultAddr = 1.
REQ-029 DIVU/REMU by zero: opA = 64'hFEDCBA0987654321, opB = 0 -> DIVU result = all-ones; REMU result = 64'hFEDCBA0987654321.
REQ-030 MULHU: opA = opB = 64'hFFFF_FFFF_FFFF_FFFF -> result = 64'hFFFF_FFFF_FFFF_FFFE.
- With MULDIV_SIGNED_EN, MULH of the same operands -> result = 0.
REQ-031 Start during busy, then rdAddr = 0:
- A second start at E0+10 with different operands is ignored, and the first result is returned.
- A following op with rdAddr = 0 gives done=1 and writeEn=0.
REQ-032 Reset mid-operation: rst_n=0 at E0+30 -> busy=0, done=0, writeEn=0, result=0 next cycle, with no done pulse; a new start then completes in 65 cycles.
REQ-033 Signed overflow with MULDIV_SIGNED_EN: DIV of 64'h8000_0000_0000_0000 by 64'hFFFF_FFFF_FFFF_FFFF -> result = 64'h8000_0000_0000_0000; REM of the same operands -> result = 0.
